score_ctrl: RTL and testbench

Match sequencer for the pong score display. It owns the two score registers that drive the score renderer's PLAYER_ONE/PLAYER_TWO inputs, and counts points from miss pulses sent by the ball logic. It also holds and releases the ball across serve delays and declares game over at a fixed winning score. The renderer shows one digit per player, so scores never exceed WIN_SCORE (max 9).

---
 rtl/score_ctrl.sv | 164 ++++++++++++++++
 tb/tb_score_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/score_ctrl.sv
// Pong match sequencer: score registers, serve delay, game-over detection.
// Optional `AUTO_RESTART_EN adds a timed restart out of GAME_OVER (RESTART_FRAMES).
module score_ctrl #(
  parameter int unsigned WIN_SCORE      = 9,
  parameter int unsigned SERVE_FRAMES   = 60,
  parameter int unsigned FRAME_CNT_W    = 8
`ifdef AUTO_RESTART_EN
  ,
  parameter int unsigned RESTART_FRAMES = 180
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       p1_miss,
  input  logic       p2_miss,
  output logic [7:0] player_one,
  output logic [7:0] player_two,
  output logic       ball_hold,
  output logic       serve_dir,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StServeWait = 3'd1,
    StPlay      = 3'd2,
    StPoint     = 3'd3,
    StGameOver  = 3'd4
  } state_e;

  localparam logic [7:0]             WinVal   = 8'(WIN_SCORE);
  localparam logic [FRAME_CNT_W-1:0] ServeEnd = FRAME_CNT_W'(SERVE_FRAMES - 1);
`ifdef AUTO_RESTART_EN
  localparam logic [FRAME_CNT_W-1:0] RestartEnd = FRAME_CNT_W'(RESTART_FRAMES - 1);
`endif

  state_e                 state_q, state_d;
  logic [7:0]             p1_q, p1_d;
  logic [7:0]             p2_q, p2_d;
  logic                   dir_q, dir_d;
  logic                   winner_q, winner_d;
  logic                   hold_q, hold_d;
  logic                   over_q, over_d;
  logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
  logic                   start_q;
  logic                   start_pulse;
  logic                   new_match;

  assign start_pulse = start & ~start_q;

  always_comb begin
    state_d   = state_q;
    p1_d      = p1_q;
    p2_d      = p2_q;
    dir_d     = dir_q;
    winner_d  = winner_q;
    cnt_d     = cnt_q;
    new_match = 1'b0;

    case (state_q)
      StIdle: begin
        if (start_pulse) new_match = 1'b1;
      end

      StServeWait: begin
        if (frame_tick) begin
          if (cnt_q == ServeEnd) begin
            state_d = StPlay;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      StPlay: begin
        if (p1_miss && !p2_miss) begin
          if (p2_q < WinVal) p2_d = p2_q + 8'd1;
          dir_d = 1'b0;
        end else if (p2_miss && !p1_miss) begin
          if (p1_q < WinVal) p1_d = p1_q + 8'd1;
          dir_d = 1'b1;
        end
        if (p1_miss || p2_miss) state_d = StPoint;
      end

      StPoint: begin
        cnt_d = '0;
        if (p1_q == WinVal || p2_q == WinVal) begin
          state_d  = StGameOver;
          winner_d = (p2_q == WinVal);
        end else begin
          state_d = StServeWait;
        end
      end

      StGameOver: begin
        if (start_pulse) begin
          new_match = 1'b1;
`ifdef AUTO_RESTART_EN
        end else if (frame_tick) begin
          if (cnt_q == RestartEnd) new_match = 1'b1;
          else                     cnt_d     = cnt_q + 1'b1;
`endif
        end
      end

      default: begin
        // Illegal codes fall back to IDLE with a clean counter.
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    if (new_match) begin
      state_d = StServeWait;
      p1_d    = '0;
      p2_d    = '0;
      dir_d   = 1'b1;
      cnt_d   = '0;
    end

    // Outputs are registered from the next state so they line up with state.
    hold_d = (state_d != StPlay);
    over_d = (state_d == StGameOver);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      p1_q     <= '0;
      p2_q     <= '0;
      dir_q    <= 1'b1;
      winner_q <= 1'b0;
      hold_q   <= 1'b1;
      over_q   <= 1'b0;
      cnt_q    <= '0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      dir_q    <= dir_d;
      winner_q <= winner_d;
      hold_q   <= hold_d;
      over_q   <= over_d;
      cnt_q    <= cnt_d;
      start_q  <= start;
    end
  end

  assign player_one = p1_q;
  assign player_two = p2_q;
  assign ball_hold  = hold_q;
  assign serve_dir  = dir_q;
  assign game_over  = over_q;
  assign winner     = winner_q;
  assign state      = state_q;

endmodule

// File: tb/tb_score_ctrl.sv
// Bench for score_ctrl: directed match scenarios then random play against a match-level model.
module tb_score_ctrl;

  localparam int unsigned Win   = 3;
  localparam int unsigned Serve = 3;
`ifdef AUTO_RESTART_EN
  localparam int unsigned Restart = 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       p1_miss = 1'b0;
  logic       p2_miss = 1'b0;
  logic [7:0] player_one, player_two;
  logic       ball_hold, serve_dir, game_over, winner;
  logic [2:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  // Match-level model: phase names, points and elapsed frames.
  int m_phase;      // 0 idle, 1 waiting to serve, 2 rally, 3 point scored, 4 match over
  int m_p1, m_p2, m_dir, m_win, m_frames, m_start_prev;

  always #5 clk = ~clk;

  score_ctrl #(
    .WIN_SCORE      (Win),
    .SERVE_FRAMES   (Serve),
    .FRAME_CNT_W    (8)
`ifdef AUTO_RESTART_EN
    ,
    .RESTART_FRAMES (Restart)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .start      (start),
    .p1_miss    (p1_miss),
    .p2_miss    (p2_miss),
    .player_one (player_one),
    .player_two (player_two),
    .ball_hold  (ball_hold),
    .serve_dir  (serve_dir),
    .game_over  (game_over),
    .winner     (winner),
    .state      (state)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_p1 = 0; m_p2 = 0; m_dir = 1; m_win = 0; m_frames = 0; m_start_prev = 0;
  endtask

  task automatic new_match();
    m_phase = 1; m_p1 = 0; m_p2 = 0; m_dir = 1; m_frames = 0;
  endtask

  task automatic model_step(input int fr, input int st, input int m1, input int m2);
    int sp;
    sp = (st != 0 && m_start_prev == 0) ? 1 : 0;
    m_start_prev = st;
    if (m_phase == 0) begin
      if (sp != 0) new_match();
    end else if (m_phase == 1) begin
      if (fr != 0) m_frames++;
      if (m_frames == Serve) begin
        m_phase = 2; m_frames = 0;
      end
    end else if (m_phase == 2) begin
      if (m1 != 0 && m2 == 0) begin m_p2 = (m_p2 < Win) ? m_p2 + 1 : m_p2; m_dir = 0; end
      if (m2 != 0 && m1 == 0) begin m_p1 = (m_p1 < Win) ? m_p1 + 1 : m_p1; m_dir = 1; end
      if (m1 != 0 || m2 != 0) m_phase = 3;
    end else if (m_phase == 3) begin
      m_frames = 0;
      if (m_p1 == Win || m_p2 == Win) begin
        m_phase = 4; m_win = (m_p2 == Win) ? 1 : 0;
      end else begin
        m_phase = 1;
      end
    end else begin
      if (sp != 0) new_match();
`ifdef AUTO_RESTART_EN
      else if (fr != 0) begin
        m_frames++;
        if (m_frames == Restart) new_match();
      end
`endif
    end
  endtask

  task automatic check_all();
    check("state", {5'd0, state}, 8'(m_phase));
    check("player_one", player_one, 8'(m_p1));
    check("player_two", player_two, 8'(m_p2));
    check("ball_hold", {7'd0, ball_hold}, (m_phase == 2) ? 8'd0 : 8'd1);
    check("serve_dir", {7'd0, serve_dir}, 8'(m_dir));
    check("game_over", {7'd0, game_over}, (m_phase == 4) ? 8'd1 : 8'd0);
    check("winner", {7'd0, winner}, 8'(m_win));
  endtask

  task automatic step(input logic fr, input logic st, input logic m1, input logic m2);
    frame_tick = fr; start = st; p1_miss = m1; p2_miss = m2;
    @(posedge clk);
    #1;
    model_step(int'(fr), int'(st), int'(m1), int'(m2));
    check_all();
  endtask

  task automatic serve();
    for (int i = 0; i < int'(Serve); i++) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    // Reset held with frame ticks: everything stays at reset values.
    for (int i = 0; i < 10; i++) begin
      frame_tick = i[0];
      @(posedge clk);
      #1;
      check_all();
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("idle_state", {5'd0, state}, 8'd0);

    // Start edge, held button, then exactly Serve ticks before release.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("start_to_wait", {5'd0, state}, 8'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("after_tick2", {5'd0, state}, 8'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("after_tick3", {5'd0, state}, 8'd2);
    check("hold_released", {7'd0, ball_hold}, 8'd0);

    // Single misses.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("p1_scored", player_one, 8'd1);
    check("point_state", {5'd0, state}, 8'd3);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("back_to_wait", {5'd0, state}, 8'd1);
    serve();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("p2_scored", player_two, 8'd1);
    check("dir_to_p1", {7'd0, serve_dir}, 8'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Double miss, then misses while waiting to serve.
    serve();
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("double_state", {5'd0, state}, 8'd3);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("wait_miss_p1", player_one, 8'd1);
    check("wait_miss_p2", player_two, 8'd1);

    // Reach 2/1 in a rally, then asynchronous reset between edges.
    serve();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    serve();
    check("rally_2_1", player_one, 8'd2);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check("async_rst_hold", {7'd0, ball_hold}, 8'd1);
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    // Player one wins to Win.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int g = 0; g < int'(Win); g++) begin
      serve();
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("win_state", {5'd0, state}, 8'd4);
    check("win_score", player_one, 8'(Win));
    check("win_over", {7'd0, game_over}, 8'd1);
    check("win_who", {7'd0, winner}, 8'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("frozen_score", player_one, 8'(Win));
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("restart_state", {5'd0, state}, 8'd1);
    check("restart_score", player_one, 8'd0);

`ifdef AUTO_RESTART_EN
    for (int g = 0; g < int'(Win); g++) begin
      serve();
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("p2_wins", {7'd0, winner}, 8'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("auto_tick1", {5'd0, state}, 8'd4);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("auto_tick2", {5'd0, state}, 8'd1);
`endif

    // Random play.
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 1) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
